// File: rtl/fifo_sync_param_if.sv
// fifo_sync_param_if: streaming and status bundle for fifo_sync_param.
// The master side is the producer/consumer pair, the slave side is the FIFO.
interface fifo_sync_param_if #(
  parameter int BITS  = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            flush;
  logic            clear_err;
  logic            shift_in;
  logic [BITS-1:0] data_in;
  logic            shift_out;
  logic [BITS-1:0] data_out;
  logic            fifo_not_empty;
  logic            fifo_full;
  logic            almost_full;
  logic            almost_empty;
  logic [CW-1:0]   words;
  logic            overflow;
  logic            underflow;

  modport master (
    output flush, clear_err, shift_in, data_in, shift_out,
    input  data_out, fifo_not_empty, fifo_full, almost_full, almost_empty,
           words, overflow, underflow
  );

  modport slave (
    input  flush, clear_err, shift_in, data_in, shift_out,
    output data_out, fifo_not_empty, fifo_full, almost_full, almost_empty,
           words, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO of DEPTH words of BITS bits with an
// optional zero-latency look-ahead path, exact fill count, threshold flags,
// synchronous flush and sticky overflow/underflow flags.
module fifo_sync_param #(
  parameter int BITS         = 8,
  parameter int DEPTH        = 16,
  parameter int ZERO_LATENCY = 1,
  parameter int ALMOST_FULL  = DEPTH - 2,
  parameter int ALMOST_EMPTY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  fifo_sync_param_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_COUNT   = CW'(ALMOST_FULL);
  localparam logic [CW-1:0] AE_COUNT   = CW'(ALMOST_EMPTY);

  logic [BITS-1:0] mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            overflow_r;
  logic            underflow_r;

  logic empty_r;
  logic full_r;
  logic pass_mode;
  logic not_empty;
  logic rd_ok;
  logic wr_ok;
  logic pass_thru;
  logic do_wr;
  logic do_rd;
  logic ovf_evt;
  logic unf_evt;

  // While empty in zero-latency mode the input word is presented directly;
  // a same-cycle read then consumes it without touching storage.
  assign empty_r   = (count == '0);
  assign full_r    = (count == FULL_COUNT);
  assign pass_mode = (ZERO_LATENCY != 0) && empty_r;
  assign not_empty = pass_mode ? bus.shift_in : !empty_r;

  assign rd_ok     = bus.shift_out && not_empty;
  assign wr_ok     = bus.shift_in && (!full_r || bus.shift_out);
  assign pass_thru = pass_mode && bus.shift_in && bus.shift_out;
  assign do_wr     = wr_ok && !pass_thru && !bus.flush;
  assign do_rd     = rd_ok && !pass_thru && !bus.flush;

  // A flush cycle discards its inputs, so it can never raise an error.
  assign ovf_evt   = bus.shift_in && full_r && !bus.shift_out && !bus.flush;
  assign unf_evt   = bus.shift_out && !not_empty && !bus.flush;

  assign bus.data_out       = pass_mode ? bus.data_in : mem[rd_ptr];
  assign bus.fifo_not_empty = not_empty;
  assign bus.fifo_full      = full_r;
  assign bus.almost_full    = (count >= AF_COUNT);
  assign bus.almost_empty   = (count <= AE_COUNT);
  assign bus.words          = count;
  assign bus.overflow       = overflow_r;
  assign bus.underflow      = underflow_r;

  // Storage write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  // Pointers and fill count advance on accepted transfers; flush rewinds them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_wr && !do_rd) begin
        count <= count + CW'(1);
      end else if (do_rd && !do_wr) begin
        count <= count - CW'(1);
      end
    end
  end

  // Sticky error flags: a new error in the same cycle as clear_err wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= ovf_evt || (overflow_r && !bus.clear_err);
      underflow_r <= unf_evt || (underflow_r && !bus.clear_err);
    end
  end
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: table-driven vectors for a registered and a
// zero-latency DEPTH=4 FIFO, a queue scoreboard for a DEPTH=8 FIFO under
// random interleave, and an asynchronous reset sequence.
module tb_fifo_sync_param;
  logic clk = 1'b0;
  logic reset_n = 1'b0;

  fifo_sync_param_if #(.BITS(8), .DEPTH(4)) bus_a ();
  fifo_sync_param_if #(.BITS(8), .DEPTH(4)) bus_b ();
  fifo_sync_param_if #(.BITS(8), .DEPTH(8)) bus_c ();

  fifo_sync_param #(.BITS(8), .DEPTH(4), .ZERO_LATENCY(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a)
  );
  fifo_sync_param #(.BITS(8), .DEPTH(4), .ZERO_LATENCY(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b)
  );
  fifo_sync_param #(.BITS(8), .DEPTH(8), .ZERO_LATENCY(0),
                    .ALMOST_FULL(6), .ALMOST_EMPTY(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .bus(bus_c)
  );

  // Free-running clock, rising edge active.
  always #5 clk = ~clk;

  typedef struct {
    bit         fl, ce, si;
    logic [7:0] di;
    bit         so;
    bit         ne;
    logic [7:0] dout;
    int         wd;
    bit         full, af, ae, ovf, unf;
  } vec_t;

  vec_t tbl_a [31];
  vec_t tbl_b [12];
  int   sel;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [7:0] exp_q [$];

  function automatic vec_t mk(input bit fl, ce, si, input logic [7:0] di, input bit so,
                              input bit ne, input logic [7:0] dout, input int wd,
                              input bit full, af, ae, ovf, unf);
    vec_t v;
    v.fl = fl; v.ce = ce; v.si = si; v.di = di; v.so = so;
    v.ne = ne; v.dout = dout; v.wd = wd;
    v.full = full; v.af = af; v.ae = ae; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idleAll();
    bus_a.flush = 0; bus_a.clear_err = 0; bus_a.shift_in = 0; bus_a.shift_out = 0; bus_a.data_in = '0;
    bus_b.flush = 0; bus_b.clear_err = 0; bus_b.shift_in = 0; bus_b.shift_out = 0; bus_b.data_in = '0;
    bus_c.flush = 0; bus_c.clear_err = 0; bus_c.shift_in = 0; bus_c.shift_out = 0; bus_c.data_in = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    idleAll();
    if (sel == 0) begin
      bus_a.flush = v.fl; bus_a.clear_err = v.ce; bus_a.shift_in = v.si;
      bus_a.data_in = v.di; bus_a.shift_out = v.so;
    end else begin
      bus_b.flush = v.fl; bus_b.clear_err = v.ce; bus_b.shift_in = v.si;
      bus_b.data_in = v.di; bus_b.shift_out = v.so;
    end
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    logic ne, full, af, ae, ovf, unf;
    logic [7:0] dout;
    logic [31:0] wd;
    if (sel == 0) begin
      ne = bus_a.fifo_not_empty; dout = bus_a.data_out; wd = 32'(bus_a.words);
      full = bus_a.fifo_full; af = bus_a.almost_full; ae = bus_a.almost_empty;
      ovf = bus_a.overflow; unf = bus_a.underflow;
    end else begin
      ne = bus_b.fifo_not_empty; dout = bus_b.data_out; wd = 32'(bus_b.words);
      full = bus_b.fifo_full; af = bus_b.almost_full; ae = bus_b.almost_empty;
      ovf = bus_b.overflow; unf = bus_b.underflow;
    end
    cmp({name, ".not_empty"}, ne, v.ne);
    if (v.ne) cmp({name, ".data_out"}, dout, v.dout);
    cmp({name, ".words"}, wd, v.wd);
    cmp({name, ".full"}, full, v.full);
    cmp({name, ".almost_full"}, af, v.af);
    cmp({name, ".almost_empty"}, ae, v.ae);
    cmp({name, ".overflow"}, ovf, v.ovf);
    cmp({name, ".underflow"}, unf, v.unf);
  endtask

  // Hard stop if the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    //              fl ce si di     so  ne dout   wd full af ae ovf unf
    tbl_a[0]  = mk(0, 0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 1, 0, 0);
    tbl_a[1]  = mk(0, 0, 1, 8'h11, 0,  0, 8'h00, 0, 0, 0, 1, 0, 0);
    tbl_a[2]  = mk(0, 0, 1, 8'h22, 0,  1, 8'h11, 1, 0, 0, 1, 0, 0);
    tbl_a[3]  = mk(0, 0, 1, 8'h33, 0,  1, 8'h11, 2, 0, 1, 0, 0, 0);
    tbl_a[4]  = mk(0, 0, 1, 8'h44, 0,  1, 8'h11, 3, 0, 1, 0, 0, 0);
    tbl_a[5]  = mk(0, 0, 1, 8'h99, 0,  1, 8'h11, 4, 1, 1, 0, 0, 0);
    tbl_a[6]  = mk(0, 1, 0, 8'h00, 0,  1, 8'h11, 4, 1, 1, 0, 1, 0);
    tbl_a[7]  = mk(0, 0, 1, 8'h55, 1,  1, 8'h11, 4, 1, 1, 0, 0, 0);
    tbl_a[8]  = mk(0, 0, 0, 8'h00, 1,  1, 8'h22, 4, 1, 1, 0, 0, 0);
    tbl_a[9]  = mk(0, 0, 0, 8'h00, 1,  1, 8'h33, 3, 0, 1, 0, 0, 0);
    tbl_a[10] = mk(0, 0, 0, 8'h00, 1,  1, 8'h44, 2, 0, 1, 0, 0, 0);
    tbl_a[11] = mk(0, 0, 0, 8'h00, 1,  1, 8'h55, 1, 0, 0, 1, 0, 0);
    tbl_a[12] = mk(0, 0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 1, 0, 0);
    tbl_a[13] = mk(0, 0, 0, 8'h00, 1,  0, 8'h00, 0, 0, 0, 1, 0, 0);
    tbl_a[14] = mk(0, 1, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 1, 0, 1);
    tbl_a[15] = mk(0, 0, 0, 8'h00, 1,  0, 8'h00, 0, 0, 0, 1, 0, 0);
    tbl_a[16] = mk(0, 1, 0, 8'h00, 1,  0, 8'h00, 0, 0, 0, 1, 0, 1);
    tbl_a[17] = mk(0, 0, 1, 8'h61, 0,  0, 8'h00, 0, 0, 0, 1, 0, 1);
    tbl_a[18] = mk(0, 0, 1, 8'h62, 0,  1, 8'h61, 1, 0, 0, 1, 0, 1);
    tbl_a[19] = mk(0, 0, 1, 8'h63, 0,  1, 8'h61, 2, 0, 1, 0, 0, 1);
    tbl_a[20] = mk(0, 0, 1, 8'h64, 0,  1, 8'h61, 3, 0, 1, 0, 0, 1);
    tbl_a[21] = mk(0, 0, 1, 8'h65, 0,  1, 8'h61, 4, 1, 1, 0, 0, 1);
    tbl_a[22] = mk(0, 0, 0, 8'h00, 1,  1, 8'h61, 4, 1, 1, 0, 1, 1);
    tbl_a[23] = mk(1, 0, 1, 8'h77, 1,  1, 8'h62, 3, 0, 1, 0, 1, 1);
    tbl_a[24] = mk(0, 1, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 1, 1, 1);
    tbl_a[25] = mk(1, 0, 1, 8'h78, 1,  0, 8'h00, 0, 0, 0, 1, 0, 0);
    tbl_a[26] = mk(0, 0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 1, 0, 0);
    tbl_a[27] = mk(0, 0, 1, 8'h81, 0,  0, 8'h00, 0, 0, 0, 1, 0, 0);
    tbl_a[28] = mk(0, 0, 0, 8'h00, 0,  1, 8'h81, 1, 0, 0, 1, 0, 0);
    tbl_a[29] = mk(0, 0, 0, 8'h00, 1,  1, 8'h81, 1, 0, 0, 1, 0, 0);
    tbl_a[30] = mk(0, 0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 1, 0, 0);

    tbl_b[0]  = mk(0, 0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 1, 0, 0);
    tbl_b[1]  = mk(0, 0, 1, 8'hA5, 1,  1, 8'hA5, 0, 0, 0, 1, 0, 0);
    tbl_b[2]  = mk(0, 0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 1, 0, 0);
    tbl_b[3]  = mk(0, 0, 1, 8'h3C, 0,  1, 8'h3C, 0, 0, 0, 1, 0, 0);
    tbl_b[4]  = mk(0, 0, 1, 8'h4D, 0,  1, 8'h3C, 1, 0, 0, 1, 0, 0);
    tbl_b[5]  = mk(0, 0, 1, 8'h5E, 1,  1, 8'h3C, 2, 0, 1, 0, 0, 0);
    tbl_b[6]  = mk(0, 0, 0, 8'h00, 1,  1, 8'h4D, 2, 0, 1, 0, 0, 0);
    tbl_b[7]  = mk(0, 0, 0, 8'h00, 1,  1, 8'h5E, 1, 0, 0, 1, 0, 0);
    tbl_b[8]  = mk(0, 0, 0, 8'h00, 1,  0, 8'h00, 0, 0, 0, 1, 0, 0);
    tbl_b[9]  = mk(0, 0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 1, 0, 1);
    tbl_b[10] = mk(0, 1, 1, 8'h66, 1,  1, 8'h66, 0, 0, 0, 1, 0, 1);
    tbl_b[11] = mk(0, 0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 1, 0, 0);

    idleAll();
    sel = 0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] registered DEPTH=4 vectors");
    sel = 0;
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      applyStimulus(tbl_a[i]);
      #1;
      checkOutput($sformatf("vecA[%0d]", i), tbl_a[i]);
    end

    $display("[TB] zero-latency DEPTH=4 vectors");
    sel = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      applyStimulus(tbl_b[i]);
      #1;
      checkOutput($sformatf("vecB[%0d]", i), tbl_b[i]);
    end

    $display("[TB] DEPTH=8 random interleave with scoreboard");
    idleAll();
    exp_q.delete();
    for (int cyc = 0; cyc < 70; cyc++) begin
      int wr_pct;
      int sz;
      bit si, so;
      logic [7:0] d;
      logic [7:0] exp_d;
      @(negedge clk);
      wr_pct = (cyc < 30) ? 75 : 35;
      si = ($urandom_range(99) < wr_pct);
      so = ($urandom_range(99) < (100 - wr_pct));
      d  = 8'($urandom_range(255));
      bus_c.shift_in = si; bus_c.shift_out = so; bus_c.data_in = d;
      #1;
      sz = exp_q.size();
      cmp($sformatf("sb[%0d].words", cyc), 32'(bus_c.words), sz);
      cmp($sformatf("sb[%0d].not_empty", cyc), bus_c.fifo_not_empty, (sz != 0));
      cmp($sformatf("sb[%0d].full", cyc), bus_c.fifo_full, (sz == 8));
      cmp($sformatf("sb[%0d].almost_full", cyc), bus_c.almost_full, (sz >= 6));
      cmp($sformatf("sb[%0d].almost_empty", cyc), bus_c.almost_empty, (sz <= 1));
      if (so && sz != 0) begin
        exp_d = exp_q.pop_front();
        cmp($sformatf("sb[%0d].data_out", cyc), bus_c.data_out, exp_d);
      end
      if (si && (sz < 8 || so)) exp_q.push_back(d);
    end

    $display("[TB] asynchronous reset with 5 words stored");
    @(negedge clk);
    idleAll();
    bus_c.flush = 1;
    @(negedge clk);
    bus_c.flush = 0;
    for (int i = 0; i < 5; i++) begin
      bus_c.shift_in = 1;
      bus_c.data_in = 8'(8'hD0 + i);
      @(negedge clk);
    end
    bus_c.shift_in = 0;
    #1;
    cmp("rst.words_before", 32'(bus_c.words), 5);
    #2;
    reset_n = 1'b0;
    #1;
    cmp("rst.words_now", 32'(bus_c.words), 0);
    cmp("rst.full_now", bus_c.fifo_full, 1'b0);
    cmp("rst.almost_empty_now", bus_c.almost_empty, 1'b1);
    cmp("rst.not_empty_now", bus_c.fifo_not_empty, 1'b0);
    cmp("rst.overflow_now", bus_c.overflow, 1'b0);
    @(negedge clk);
    #1;
    cmp("rst.words_held", 32'(bus_c.words), 0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_c.shift_in = 1;
    bus_c.data_in = 8'hC3;
    @(negedge clk);
    bus_c.shift_in = 0;
    #1;
    cmp("rst.first_not_empty", bus_c.fifo_not_empty, 1'b1);
    cmp("rst.first_data", bus_c.data_out, 8'hC3);
    cmp("rst.first_words", 32'(bus_c.words), 1);
    bus_c.shift_out = 1;
    @(negedge clk);
    bus_c.shift_out = 0;
    #1;
    cmp("rst.drained_not_empty", bus_c.fifo_not_empty, 1'b0);
    cmp("rst.drained_words", 32'(bus_c.words), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
